// File: rtl/irrigation_timer_pkg.sv
// Shared types and helpers for the irrigation countdown timer: FSM states,
// BCD digit types, default preset digits and the one-second BCD decrement.
package irrigation_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  // Widest minutes-tens digit supported. Narrower instances keep the upper
  // bits at zero and only drive MIN_TENS_WIDTH bits out.
  localparam int MT_MAX_W = 8;

  typedef logic [3:0]          bcd_digit_t;
  typedef logic [2:0]          bcd_sec_tens_t;
  typedef logic [MT_MAX_W-1:0] bcd_min_tens_t;

  typedef struct packed {
    bcd_min_tens_t min_tens;
    bcd_digit_t    min_units;
    bcd_sec_tens_t sec_tens;
    bcd_digit_t    sec_units;
  } bcd_time_t;

  typedef struct packed {
    bcd_time_t t;
    logic      zero;
  } bcd_dec_t;

  // Default presets, split into display digits.
  localparam int DEF_SPRINKLER_MIN = 15;
  localparam int DEF_SPRINKLER_SEC = 0;
  localparam int DEF_DRIPPER_MIN   = 30;
  localparam int DEF_DRIPPER_SEC   = 0;

  localparam int DEF_SPRINKLER_MIN_TENS  = DEF_SPRINKLER_MIN / 10;
  localparam int DEF_SPRINKLER_MIN_UNITS = DEF_SPRINKLER_MIN % 10;
  localparam int DEF_SPRINKLER_SEC_TENS  = DEF_SPRINKLER_SEC / 10;
  localparam int DEF_SPRINKLER_SEC_UNITS = DEF_SPRINKLER_SEC % 10;
  localparam int DEF_DRIPPER_MIN_TENS    = DEF_DRIPPER_MIN / 10;
  localparam int DEF_DRIPPER_MIN_UNITS   = DEF_DRIPPER_MIN % 10;
  localparam int DEF_DRIPPER_SEC_TENS    = DEF_DRIPPER_SEC / 10;
  localparam int DEF_DRIPPER_SEC_UNITS   = DEF_DRIPPER_SEC % 10;

  // Split a minutes/seconds preset into BCD digits (elaboration-time use).
  function automatic bcd_time_t preset_to_bcd(input int mins, input int secs);
    bcd_time_t t;
    t.min_tens  = bcd_min_tens_t'(mins / 10);
    t.min_units = bcd_digit_t'(mins % 10);
    t.sec_tens  = bcd_sec_tens_t'(secs / 10);
    t.sec_units = bcd_digit_t'(secs % 10);
    return t;
  endfunction

  // Subtract one second with the BCD borrow chain. A zero input stays zero
  // (saturates) so a stray tick at 00:00 can never wrap the display.
  function automatic bcd_dec_t bcd_sec_decrement(input bcd_time_t t);
    bcd_dec_t r;
    r.t = t;
    if (t != '0) begin
      if (t.sec_units != 4'd0) begin
        r.t.sec_units = t.sec_units - 4'd1;
      end else begin
        r.t.sec_units = 4'd9;
        if (t.sec_tens != 3'd0) begin
          r.t.sec_tens = t.sec_tens - 3'd1;
        end else begin
          r.t.sec_tens = 3'd5;
          if (t.min_units != 4'd0) begin
            r.t.min_units = t.min_units - 4'd1;
          end else begin
            r.t.min_units = 4'd9;
            r.t.min_tens  = t.min_tens - bcd_min_tens_t'(1);
          end
        end
      end
    end
    r.zero = (r.t == '0);
    return r;
  endfunction

endpackage

// File: rtl/irrigation_countdown_timer_prescaler.sv
// One-second tick generator: counts enabled cycles 0..TICKS_PER_SECOND-1 and
// flags the terminal count. Holds its value while disabled so a paused
// countdown resumes mid-second.
module tick_prescaler #(
  parameter int TICKS_PER_SECOND = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A single-count prescaler still needs a one-bit register to exist.
  localparam int CW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SECOND - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = enable && !clear && at_last;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/irrigation_countdown_timer.sv
// Irrigation countdown timer: BCD MM:SS countdown with per-mode presets,
// load/run/hold/expire sequencing and a done pulse for the valve logic.
module irrigation_countdown_timer
  import irrigation_timer_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 50_000_000,
  parameter int MIN_TENS_WIDTH   = 2,
  parameter int SPRINKLER_MIN    = DEF_SPRINKLER_MIN,
  parameter int SPRINKLER_SEC    = DEF_SPRINKLER_SEC,
  parameter int DRIPPER_MIN      = DEF_DRIPPER_MIN,
  parameter int DRIPPER_SEC      = DEF_DRIPPER_SEC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      irrigation_on,
  input  logic                      sprinkler_mode_on,
  input  logic                      conflicting_values,
  input  logic                      forced_restart,
  output logic [MIN_TENS_WIDTH-1:0] minutes_tens,
  output logic [3:0]                minutes_units,
  output logic [2:0]                seconds_tens,
  output logic [3:0]                seconds_units,
  output logic                      running,
  output logic                      expired,
  output logic                      done
);

  localparam int MAX_MINUTES = 10 * (2 ** MIN_TENS_WIDTH) - 1;

  // Reject unusable configurations before they reach silicon.
  if (TICKS_PER_SECOND < 1) begin : g_bad_tps
    $error("TICKS_PER_SECOND must be at least 1");
  end
  if (MIN_TENS_WIDTH < 1 || MIN_TENS_WIDTH > MT_MAX_W) begin : g_bad_width
    $error("MIN_TENS_WIDTH out of range");
  end
  if (SPRINKLER_MIN < 0 || SPRINKLER_MIN > MAX_MINUTES ||
      SPRINKLER_SEC < 0 || SPRINKLER_SEC > 59) begin : g_bad_spr
    $error("sprinkler preset out of range");
  end
  if (DRIPPER_MIN < 0 || DRIPPER_MIN > MAX_MINUTES ||
      DRIPPER_SEC < 0 || DRIPPER_SEC > 59) begin : g_bad_drp
    $error("dripper preset out of range");
  end

  localparam bcd_time_t SPR_PRESET = preset_to_bcd(SPRINKLER_MIN, SPRINKLER_SEC);
  localparam bcd_time_t DRP_PRESET = preset_to_bcd(DRIPPER_MIN, DRIPPER_SEC);

  timer_state_t state_q, state_d;
  bcd_time_t    digits_q, digits_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;
  logic         done_q, done_d;

  bcd_time_t    preset_sel;
  bcd_dec_t     dec;
  logic         presc_en, presc_clr, tick;

  assign preset_sel = sprinkler_mode_on ? SPR_PRESET : DRP_PRESET;
  assign dec        = bcd_sec_decrement(digits_q);

  // The prescaler only advances in an undisturbed RUNNING cycle, so a tick
  // that lands on a restart or conflict is dropped. It is zeroed whenever the
  // digits are (re)loaded and while idle or expired; HOLD leaves it alone.
  assign presc_en  = irrigation_on && !forced_restart && !conflicting_values &&
                     (state_q == RUNNING);
  assign presc_clr = !irrigation_on ||
                     (forced_restart && state_q != IDLE) ||
                     (state_q == IDLE) || (state_q == EXPIRED);

  tick_prescaler #(
    .TICKS_PER_SECOND(TICKS_PER_SECOND)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (tick)
  );

  // Next state and digits, priority: irrigation off, forced restart,
  // conflict, then the one-second tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    if (!irrigation_on) begin
      state_d  = IDLE;
      digits_d = preset_sel;
    end else if (forced_restart && state_q != IDLE) begin
      digits_d = preset_sel;
      if (conflicting_values)   state_d = HOLD;
      else if (preset_sel == '0) state_d = EXPIRED;
      else                       state_d = RUNNING;
    end else begin
      case (state_q)
        IDLE: begin
          // Display always shows the duration that a start would load.
          digits_d = preset_sel;
          if (!conflicting_values) begin
            state_d = (preset_sel == '0) ? EXPIRED : RUNNING;
          end
        end
        RUNNING: begin
          if (conflicting_values) begin
            state_d = HOLD;
          end else if (tick) begin
            digits_d = dec.t;
            if (dec.zero) state_d = EXPIRED;
          end
        end
        HOLD: begin
          if (!conflicting_values) state_d = RUNNING;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    running_d = (state_d == RUNNING);
    expired_d = (state_d == EXPIRED);
    done_d    = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

  // FSM, digit and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign minutes_tens  = digits_q.min_tens[MIN_TENS_WIDTH-1:0];
  assign minutes_units = digits_q.min_units;
  assign seconds_tens  = digits_q.sec_tens;
  assign seconds_units = digits_q.sec_units;
  assign running       = running_q;
  assign expired       = expired_q;
  assign done          = done_q;

endmodule
